// File: rtl/serial_adder.sv
// Multi-cycle two's-complement adder/subtractor: adds SLICE bits per clock through a
// registered carry, with a start/busy/done handshake and held result registers.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int SLICE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V,
    output logic             busy,
    output logic             done
);

    localparam int N     = WIDTH / SLICE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    if (WIDTH < 2 || (WIDTH % SLICE) != 0) begin : g_bad_params
        $error("serial_adder: WIDTH must be >= 2 and an integer multiple of SLICE");
    end

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] psum_q, psum_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             v_q, v_d;
    logic             done_q, done_d;

    logic [SLICE:0]   slice_full;
    logic [SLICE-1:0] slice_sum;
    logic             slice_cout;
    logic             msb_cin;
    logic [WIDTH-1:0] sum_ext;

    // Carry into the slice MSB is recovered from the MSB sum bit, avoiding a second adder.
    always_comb begin : slice_add
        slice_full = {1'b0, opa_q[SLICE-1:0]} + {1'b0, opb_q[SLICE-1:0]}
                   + {{SLICE{1'b0}}, carry_q};
        slice_sum  = slice_full[SLICE-1:0];
        slice_cout = slice_full[SLICE];
        msb_cin    = slice_sum[SLICE-1] ^ opa_q[SLICE-1] ^ opb_q[SLICE-1];
        sum_ext    = WIDTH'(slice_sum);
    end

    always_comb begin : next_state
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        psum_d  = psum_q;
        s_d     = s_q;
        cout_d  = cout_q;
        v_d     = v_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    opa_d   = A;
                    opb_d   = Sub ? ~B : B;
                    carry_d = Cin ^ Sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                opa_d   = opa_q >> SLICE;
                opb_d   = opb_q >> SLICE;
                psum_d  = (psum_q >> SLICE) | (sum_ext << (WIDTH - SLICE));
                carry_d = slice_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    s_d     = psum_d;
                    cout_d  = slice_cout;
                    v_d     = msb_cin ^ slice_cout;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin : regs
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            psum_q  <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            v_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            psum_q  <= psum_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            v_q     <= v_d;
            done_q  <= done_d;
        end
    end

    assign S    = s_q;
    assign Cout = cout_q;
    assign V    = v_q;
    assign busy = (state_q == RUN);
    assign done = done_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomised checks of serial_adder across several WIDTH/SLICE configurations.
module tb_serial_adder;

    logic clk;
    logic rst_n_r;
    logic rst_n_d1;
    int   n_chk;
    int   n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // WIDTH=8, SLICE=1 instance for directed tests (own reset for the mid-op abort)
    logic       d1_start, d1_Cin, d1_Sub, d1_Cout, d1_V, d1_busy, d1_done;
    logic [7:0] d1_A, d1_B, d1_S;

    serial_adder #(.WIDTH(8), .SLICE(1)) u_d1 (
        .clk(clk), .rst_n(rst_n_d1), .start(d1_start), .A(d1_A), .B(d1_B),
        .Cin(d1_Cin), .Sub(d1_Sub), .S(d1_S), .Cout(d1_Cout), .V(d1_V),
        .busy(d1_busy), .done(d1_done)
    );

    // WIDTH=8, SLICE=4 instance for directed tests
    logic       d4_start, d4_Cin, d4_Sub, d4_Cout, d4_V, d4_busy, d4_done;
    logic [7:0] d4_A, d4_B, d4_S;

    serial_adder #(.WIDTH(8), .SLICE(4)) u_d4 (
        .clk(clk), .rst_n(rst_n_r), .start(d4_start), .A(d4_A), .B(d4_B),
        .Cin(d4_Cin), .Sub(d4_Sub), .S(d4_S), .Cout(d4_Cout), .V(d4_V),
        .busy(d4_busy), .done(d4_done)
    );

    // Called on a falling edge; returns on the falling edge after busy drops.
    task automatic run_d1(input logic [7:0] a, input logic [7:0] b, input logic ci,
                          input logic sb, output int bcnt, output bit stable);
        logic [7:0] prev;
        prev     = d1_S;
        d1_A     = a;
        d1_B     = b;
        d1_Cin   = ci;
        d1_Sub   = sb;
        d1_start = 1'b1;
        @(negedge clk);
        d1_start = 1'b0;
        bcnt     = 0;
        stable   = 1'b1;
        while (d1_busy && bcnt < 40) begin
            bcnt++;
            if (d1_S != prev) stable = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic run_d4(input logic [7:0] a, input logic [7:0] b, input logic ci,
                          input logic sb, output int bcnt);
        d4_A     = a;
        d4_B     = b;
        d4_Cin   = ci;
        d4_Sub   = sb;
        d4_start = 1'b1;
        @(negedge clk);
        d4_start = 1'b0;
        bcnt     = 0;
        while (d4_busy && bcnt < 40) begin
            bcnt++;
            @(negedge clk);
        end
    endtask

    // Randomised reference checks, one block per configuration
    for (genvar g = 0; g < 4; g++) begin : g_rand
        localparam int W  = (g < 2) ? 8 : 16;
        localparam int SL = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 16;
        localparam int N  = W / SL;

        logic         st, ci, sb, co, v, bz, dn, fin;
        logic [W-1:0] a, b, s, bb;
        logic [W:0]   full;
        logic         vexp;
        int           k;

        serial_adder #(.WIDTH(W), .SLICE(SL)) u_dut (
            .clk(clk), .rst_n(rst_n_r), .start(st), .A(a), .B(b),
            .Cin(ci), .Sub(sb), .S(s), .Cout(co), .V(v),
            .busy(bz), .done(dn)
        );

        initial begin
            fin = 1'b0;
            st  = 1'b0;
            a   = '0;
            b   = '0;
            ci  = 1'b0;
            sb  = 1'b0;
            wait (rst_n_r === 1'b1);
            @(negedge clk);
            for (int i = 0; i < 1000; i++) begin
                a  = W'($urandom);
                b  = W'($urandom);
                ci = 1'($urandom_range(0, 1));
                sb = 1'($urandom_range(0, 1));
                bb   = sb ? ~b : b;
                full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, ci ^ sb};
                vexp = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
                st = 1'b1;
                @(negedge clk);
                st = 1'b0;
                k = 0;
                while (!dn && k < N + 4) begin
                    @(negedge clk);
                    k++;
                end
                chk($sformatf("rnd%0d_done", g), 32'(dn), 32'd1);
                chk($sformatf("rnd%0d_S", g), 32'(s), 32'(full[W-1:0]));
                chk($sformatf("rnd%0d_Cout", g), 32'(co), 32'(full[W]));
                chk($sformatf("rnd%0d_V", g), 32'(v), 32'(vexp));
            end
            fin = 1'b1;
        end
    end

    int         bcnt, ndone, t_prev, k;
    bit         stable, all_fin;
    logic [7:0] last_s;

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        rst_n_r  = 1'b0;
        rst_n_d1 = 1'b0;
        d1_start = 1'b0; d1_A = '0; d1_B = '0; d1_Cin = 1'b0; d1_Sub = 1'b0;
        d4_start = 1'b0; d4_A = '0; d4_B = '0; d4_Cin = 1'b0; d4_Sub = 1'b0;

        #3;
        chk("rst_S", 32'(d1_S), 32'h0);
        chk("rst_Cout", 32'(d1_Cout), 32'h0);
        chk("rst_V", 32'(d1_V), 32'h0);
        chk("rst_busy", 32'(d1_busy), 32'h0);
        chk("rst_done", 32'(d1_done), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n_r  = 1'b1;
        rst_n_d1 = 1'b1;

        run_d1(8'h5A, 8'h3C, 1'b0, 1'b0, bcnt, stable);
        chk("add1_busy_cycles", 32'(bcnt), 32'd8);
        chk("add1_S_held", 32'(stable), 32'd1);
        chk("add1_done", 32'(d1_done), 32'd1);
        chk("add1_S", 32'(d1_S), 32'h96);
        chk("add1_Cout", 32'(d1_Cout), 32'd0);
        chk("add1_V", 32'(d1_V), 32'd1);
        @(negedge clk);
        chk("add1_done_pulse", 32'(d1_done), 32'd0);

        run_d1(8'hFF, 8'h01, 1'b0, 1'b0, bcnt, stable);
        chk("wrap_S", 32'(d1_S), 32'h00);
        chk("wrap_Cout", 32'(d1_Cout), 32'd1);
        chk("wrap_V", 32'(d1_V), 32'd0);

        run_d1(8'h10, 8'h20, 1'b0, 1'b1, bcnt, stable);
        chk("sub_S", 32'(d1_S), 32'hF0);
        chk("sub_Cout", 32'(d1_Cout), 32'd0);
        chk("sub_V", 32'(d1_V), 32'd0);

        run_d4(8'h7F, 8'h01, 1'b0, 1'b0, bcnt);
        chk("s4_busy_cycles", 32'(bcnt), 32'd2);
        chk("s4_done", 32'(d4_done), 32'd1);
        chk("s4_S", 32'(d4_S), 32'h80);
        chk("s4_Cout", 32'(d4_Cout), 32'd0);
        chk("s4_V", 32'(d4_V), 32'd1);
        run_d4(8'h00, 8'h00, 1'b1, 1'b0, bcnt);
        chk("s4_cin_S", 32'(d4_S), 32'h01);

        // Start while busy must be ignored
        @(negedge clk);
        d1_A = 8'h11; d1_B = 8'h22; d1_Cin = 1'b0; d1_Sub = 1'b0;
        d1_start = 1'b1;
        @(negedge clk);
        d1_start = 1'b0;
        @(negedge clk);
        d1_A = 8'h40; d1_B = 8'h40; d1_Sub = 1'b1;
        d1_start = 1'b1;
        @(negedge clk);
        d1_start = 1'b0;
        k = 0;
        while (!d1_done && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("hs_done", 32'(d1_done), 32'd1);
        chk("hs_S", 32'(d1_S), 32'h33);
        repeat (3) @(negedge clk);
        chk("hs_idle", 32'(d1_busy), 32'd0);
        chk("hs_S_hold", 32'(d1_S), 32'h33);

        // start held high: back-to-back operations, new operands taken at each done
        last_s = d1_S;
        ndone  = 0;
        t_prev = 0;
        stable = 1'b1;
        d1_A = 8'h01; d1_B = 8'h02; d1_Cin = 1'b0; d1_Sub = 1'b0;
        d1_start = 1'b1;
        for (int c = 1; c <= 40 && ndone < 3; c++) begin
            @(negedge clk);
            if (d1_done) begin
                chk($sformatf("hold_S%0d", ndone), 32'(d1_S), 32'(8'h03 + 8'(ndone)));
                if (ndone > 0) chk("hold_period", 32'(c - t_prev), 32'd9);
                t_prev = c;
                ndone++;
                last_s = d1_S;
                d1_A   = d1_A + 8'h01;
            end else if (d1_S != last_s) begin
                stable = 1'b0;
            end
        end
        d1_start = 1'b0;
        chk("hold_ndone", 32'(ndone), 32'd3);
        chk("hold_S_stable", 32'(stable), 32'd1);
        @(negedge clk);
        chk("hold_stopped", 32'(d1_busy), 32'd0);

        // Asynchronous reset during slice 3
        d1_A = 8'h5A; d1_B = 8'h3C; d1_Cin = 1'b0; d1_Sub = 1'b0;
        d1_start = 1'b1;
        @(posedge clk);
        #1 d1_start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n_d1 = 1'b0;
        #1;
        chk("abort_S", 32'(d1_S), 32'h0);
        chk("abort_Cout", 32'(d1_Cout), 32'h0);
        chk("abort_V", 32'(d1_V), 32'h0);
        chk("abort_busy", 32'(d1_busy), 32'h0);
        chk("abort_done", 32'(d1_done), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n_d1 = 1'b1;
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (d1_done) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        run_d1(8'h12, 8'h34, 1'b0, 1'b0, bcnt, stable);
        chk("after_abort_busy", 32'(bcnt), 32'd8);
        chk("after_abort_S", 32'(d1_S), 32'h46);

        all_fin = 1'b0;
        for (int c = 0; c < 15000 && !all_fin; c++) begin
            @(negedge clk);
            all_fin = g_rand[0].fin && g_rand[1].fin && g_rand[2].fin && g_rand[3].fin;
        end
        chk("rand_finished", 32'(all_fin), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised multi-cycle two's-complement adder/subtractor. It processes two WIDTH-bit operands SLICE bits per clock, using a registered carry chain between slices. It sits alongside the combinational full adder as the area-lean arithmetic unit for datapaths where a wide adder would be too large. It uses a start/busy/done handshake and holds the registered result and flags until the next operation completes.

## Interface
- WIDTH, 8: operand and result width in bits; must be ≥ 2.
- SLICE, 1: bits added per clock; WIDTH must be an integer multiple of SLICE. N = WIDTH/SLICE cycles per operation.
- clk  input  1  rising-edge clock; the block's only clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request an operation; sampled only in IDLE.
- A  input  WIDTH  operand A, captured on the accepting edge.
- B  input  WIDTH  operand B, captured on the accepting edge.
- Cin  input  1  carry-in for add; borrow control for subtract; captured on the accepting edge.
- Sub  input  1  0 = A+B+Cin; 1 = A+~B+~Cin, i.e. A−B−Cin; captured on the accepting edge.
- S  output  WIDTH  registered result.
- Cout  output  1  carry out of the MSB. In subtract mode, 1 means no borrow.
- V  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when S, Cout and V update.

## Operation
- States: IDLE, RUN. Slice counter is ceil(log2(N)) bits wide, minimum 1.
- Reset (rst_n=0, asynchronous):
  - state=IDLE, counter=0, carry register=0.
  - Operand and partial-sum registers are cleared.
  - S=0, Cout=0, V=0, busy=0, done=0.
- IDLE with start=1 at an edge:
  - Latch A into opA.
  - Latch B into opB, or ~B when Sub=1.
  - Carry register ← Cin XOR Sub.
  - Counter ← 0, state ← RUN.
- IDLE with start=0: hold all registers. done is 0 except in the single cycle after completion.
- RUN, each edge:
  - Add the low SLICE bits of opA, opB and the carry register.
  - Shift opA and opB right by SLICE.
  - Place the SLICE-bit sum into the partial-sum register from the MSB end (shift right by SLICE).
  - Carry register ← slice carry-out; counter increments.
- RUN, on the edge where counter = N−1 (the last slice):
  - S ← the completed partial sum.
  - Cout ← the final carry.
  - V ← carry into bit WIDTH−1 XOR carry out of bit WIDTH−1, both taken from within the last slice.
  - done ← 1; state ← IDLE.
- Arithmetic is modulo 2^WIDTH. Sub, Cin, A and B changes during RUN have no effect.
- S, Cout and V keep the previous result throughout RUN. They change only on the completion edge.

## Timing
- Accepting edge k (IDLE, start=1): busy=1 from edge k.
- Slice i is processed on edge k+1+i, for i = 0..N−1.
- Completion edge k+N: busy=0, done=1 for exactly one cycle, S/Cout/V valid from then on.
- Latency from start to done is N cycles. Throughput is one operation per N+1 cycles when start is held high.
- start=1 while busy: ignored; no queuing, no error flag.
- start=1 in the cycle done is high: the state is IDLE, so the request is accepted on that edge. done still deasserts on the following edge.
- rst_n asserted mid-RUN: the operation is aborted immediately and no done is produced. After release, the block is in IDLE with all outputs 0.
- rst_n deassertion is assumed synchronised externally. The first accepting edge is the first rising edge with rst_n=1.
- SLICE=WIDTH (N=1): result is available one edge after the accepting edge, busy high for one cycle.

## Test plan
- WIDTH=8, SLICE=1:
  - Stimulus: A=0x5A, B=0x3C, Cin=0, Sub=0, start pulse.
  - Response: busy high 8 cycles, then done pulse, S=0x96, Cout=0, V=1.
- WIDTH=8, SLICE=1:
  - Stimulus: A=0xFF, B=0x01, Cin=0, Sub=0.
  - Response: S=0x00, Cout=1, V=0. Then A=0x10, B=0x20, Sub=1, Cin=0 gives S=0xF0, Cout=0, V=0.
- WIDTH=8, SLICE=4:
  - Stimulus: A=0x7F, B=0x01, Cin=0.
  - Response: done two cycles after the accepting edge, S=0x80, Cout=0, V=1. Cin=1 with A=0x00, B=0x00 gives S=0x01.
- Handshake:
  - Stimulus: start again during busy with different operands; then start held high continuously.
  - Response: the second request is ignored and the first result is unchanged. With start held high, back-to-back operations complete every N+1 cycles, and S stays stable until each done.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 at slice 3 of 8, asynchronously between edges.
  - Response: outputs go to 0 immediately and no done follows. The next start after release produces a correct result.
- Randomised self-check:
  - Stimulus: 1000 random A/B/Cin/Sub for (WIDTH, SLICE) = (8,1), (8,2), (16,4), (16,16).
  - Response: S, Cout and V match the reference model A±B computed at WIDTH+1 bits.
